// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg
// Shared definitions for the multiply/divide unit: operation encoding, FSM
// state encoding and small decode helpers used by mdu_unit.
// ============================================================================
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // Operations that occupy the unit for more than one cycle.
    function automatic logic mdu_is_multi(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// ============================================================================
// mdu_divider
// 32-bit iterative unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; 32 cycles later quotient/remainder hold
// the result until the next start.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start            load dividend/divisor and begin iterating
//   dividend[31:0]   unsigned dividend
//   divisor[31:0]    unsigned divisor (0 yields quotient all-ones,
//                    remainder = dividend)
//   busy             iterations still outstanding
//   quotient[31:0]   quotient (valid when !busy)
//   remainder[31:0]  remainder (valid when !busy)
// ============================================================================
module mdu_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;

    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;

    // Partial remainder shifted left by one, pulling in the next dividend bit.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    // Only used when w_ge, where the true difference is below r_dvs and fits.
    assign w_diff  = w_shift[31:0] - r_dvs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
            r_cnt <= 6'd32;
        end else if (r_cnt != '0) begin
            r_rem <= w_ge ? w_diff : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_ge};
            r_cnt <= r_cnt - 6'd1;
        end
    end

    assign busy      = (r_cnt != '0);
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/mdu_unit.sv
// ============================================================================
// mdu_unit
// Multi-cycle multiply/divide unit for the Execute stage. Owns the
// architectural HI/LO registers and stalls the pipeline through `done`.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   start         E-stage instruction is an MDU op
//   op[2:0]       mdu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//   a[31:0]       rs operand (post-forwarding)
//   b[31:0]       rt operand (post-forwarding)
//   hold          E stalled by something else; defers the HI/LO commit
//   flush         kill the E-stage op; no commit
//   done          0 = multi-cycle op in flight, stall E
//   hi[31:0]      architectural HI
//   lo[31:0]      architectural LO
//
// Parameters:
//   MUL_LATENCY   accept-to-done cycles for MULT/MULTU (1..8)
//   DIV_ITER      divider iterations (32)
//
// Build option:
//   MDU_FAST_DIV0_EN  when defined, DIV/DIVU by zero skips BUSY and reports
//                     done the cycle after accept.
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned DIV_ITER    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic                hold,
    input  logic                flush,
    output logic                done,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    // Counter holds BUSY cycles remaining minus one; the accept cycle is the
    // first cycle with done=0, so a multiply spends MUL_LATENCY-1 cycles in BUSY.
    localparam logic [4:0] L_MUL_LOAD = (MUL_LATENCY >= 2) ? 5'(MUL_LATENCY - 2) : 5'd0;
    localparam logic [4:0] L_DIV_LOAD = 5'(DIV_ITER - 1);

    mdu_state_t  r_state;
    logic [4:0]  r_cnt;
    mdu_op_t     r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    mdu_op_t     w_op;
    logic        w_idle;
    logic        w_accept;
    logic        w_mt_wr;
    logic        w_in_div;
    logic        w_skip_busy;
    logic        w_fast_div0;
    logic        w_busy_last;

    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic        w_div_busy;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;

    logic        w_sext;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_qneg;
    logic        w_rneg;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_op     = mdu_op_t'(op);
    assign w_idle   = (r_state == IDLE);
    assign w_in_div = mdu_is_div(w_op);
    assign w_accept = w_idle & start & ~flush & mdu_is_multi(w_op);
    assign w_mt_wr  = w_idle & start & ~flush &
                      ((w_op == MDU_MTHI) | (w_op == MDU_MTLO));

`ifdef MDU_FAST_DIV0_EN
    assign w_fast_div0 = w_in_div & (b == '0);
`else
    assign w_fast_div0 = 1'b0;
`endif

    assign w_skip_busy = w_fast_div0 | (~w_in_div & (MUL_LATENCY == 1));

    // ------------------------------------------------------------------
    // Divider: fed operand magnitudes at accept, signs restored below.
    // ------------------------------------------------------------------
    assign w_dvd_mag = ((w_op == MDU_DIV) && a[31]) ? (~a + 32'd1) : a;
    assign w_dvs_mag = ((w_op == MDU_DIV) && b[31]) ? (~b + 32'd1) : b;

    mdu_divider u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (w_accept & w_in_div),
        .dividend  (w_dvd_mag),
        .divisor   (w_dvs_mag),
        .busy      (w_div_busy),
        .quotient  (w_div_q),
        .remainder (w_div_r)
    );

    // The divider is still on its final iteration when the counter hits 0.
    assign w_busy_last = (r_cnt == '0) & (~mdu_is_div(r_op) | w_div_busy);

    // ------------------------------------------------------------------
    // Result formation from the latched operands.
    // ------------------------------------------------------------------
    assign w_sext  = mdu_is_signed(r_op);
    assign w_mul_a = {{32{w_sext & r_a[31]}}, r_a};
    assign w_mul_b = {{32{w_sext & r_b[31]}}, r_b};
    // Low 64 bits of the extended product are correct for both signednesses.
    assign w_prod  = w_mul_a * w_mul_b;
    assign w_qneg  = w_sext & (r_a[31] ^ r_b[31]);
    assign w_rneg  = w_sext & r_a[31];

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (mdu_is_div(r_op)) begin
            if (r_b == '0) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rneg ? (~w_div_r + 32'd1) : w_div_r;
                w_res_lo = w_qneg ? (~w_div_q + 32'd1) : w_div_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and architectural HI/LO.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= MDU_MULT;
            r_a     <= '0;
            r_b     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mt_wr) begin
                        if (w_op == MDU_MTHI) hi <= a;
                        else                  lo <= a;
                    end
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= w_in_div ? L_DIV_LOAD : L_MUL_LOAD;
                        r_state <= w_skip_busy ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_busy_last) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                DONE: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (!hold) begin
                        hi      <= w_res_hi;
                        lo      <= w_res_lo;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        done = 1'b1;
        case (r_state)
            IDLE:    done = ~w_accept;
            BUSY:    done = 1'b0;
            DONE:    done = 1'b1;
            default: done = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// ============================================================================
// tb_mdu_unit
// Self-checking bench for mdu_unit: expected HI/LO pairs are queued when an
// operation is issued and compared when the unit commits.
// ============================================================================
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;
    logic        flush;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit #(.MUL_LATENCY(MUL_LAT), .DIV_ITER(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hold   (hold),
        .flush  (flush),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers.
    function automatic exp_t model(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.hi = '0;
        e.lo = '0;
        case (o)
            MDU_MULT: begin
                p = 64'(sx * sy);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                if (y == 32'd0) begin
                    e.hi = x;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    if (o == MDU_DIVU) begin
                        sx = longint'({32'd0, x});
                        sy = longint'({32'd0, y});
                    end
                    q = sx / sy;
                    r = sx % sy;
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input string tag, input mdu_op_t o, input logic [31:0] x,
                          input logic [31:0] y, input int hold_n);
        int   lat;
        int   exp_lat;
        exp_t e;
        sb.push_back(model(o, x, y));
        exp_lat = (o == MDU_DIV || o == MDU_DIVU) ? 33 : int'(MUL_LAT);
`ifdef MDU_FAST_DIV0_EN
        if ((o == MDU_DIV || o == MDU_DIVU) && y == 32'd0) exp_lat = 1;
`endif
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        chk({tag, "_acc_done"}, 64'(done), 64'd0);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!done && lat < 100);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold_n; i++) begin
            hold = 1'b1;
            #1;
            chk({tag, "_hold_done"}, 64'(done), 64'd1);
            chk({tag, "_hold_nocommit"}, {hi, lo}, {m_hi, m_lo});
            step();
        end
        hold = 1'b0;
        step();
        start = 1'b0;
        #1;
        e = sb.pop_front();
        chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
        step();
        chk({tag, "_no_restart"}, 64'(done), 64'd1);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        hold   = 1'b0;
        flush  = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
        #12;
        chk("rst_done", 64'(done), 64'd1);
        chk("rst_hilo", {hi, lo}, 64'd0);
        resetn = 1'b1;
        step();

        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 0);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 0);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_by0", MDU_DIV, 32'd5, 32'd0, 0);
        run_op("divu_by0", MDU_DIVU, 32'hDEAD_BEEF, 32'd0, 0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("multu_hold", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 4);

        // Flush a divide mid-flight at cycle 10.
        start = 1'b1;
        op    = MDU_DIV;
        a     = 32'd1000;
        b     = 32'd3;
        #1;
        chk("fl_acc_done", 64'(done), 64'd0);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        #1;
        chk("fl_busy_done", 64'(done), 64'd0);
        step();
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("fl_idle_done", 64'(done), 64'd1);
        chk("fl_hilo_kept", {hi, lo}, {m_hi, m_lo});
        step();
        chk("fl_stay_idle", 64'(done), 64'd1);
        run_op("mult_after_fl", MDU_MULT, 32'h0001_0000, 32'hFFFF_0000, 0);

        // Flush in the accept cycle: op must not be taken.
        start = 1'b1;
        op    = MDU_DIVU;
        a     = 32'd77;
        b     = 32'd5;
        flush = 1'b1;
        #1;
        chk("accfl_done", 64'(done), 64'd1);
        step();
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("accfl_idle", 64'(done), 64'd1);
        step();
        chk("accfl_hilo", {hi, lo}, {m_hi, m_lo});

        // MTHI then MTLO back to back.
        start = 1'b1;
        op    = MDU_MTHI;
        a     = 32'h1234;
        #1;
        chk("mthi_done", 64'(done), 64'd1);
        step();
        op = MDU_MTLO;
        a  = 32'h5678;
        #1;
        chk("mtlo_done", 64'(done), 64'd1);
        step();
        start = 1'b0;
        #1;
        m_hi = 32'h1234;
        m_lo = 32'h5678;
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));

        // Random operations through the scoreboard.
        for (int i = 0; i < 6; i++) begin
            mdu_op_t ro;
            ro = mdu_op_t'(3'($urandom_range(0, 3)));
            run_op($sformatf("rnd%0d", i), ro, $urandom(), $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom(), i % 2);
        end

        // Asynchronous reset in the middle of a divide.
        start = 1'b1;
        op    = MDU_DIV;
        a     = 32'd12345;
        b     = 32'd17;
        for (int i = 0; i < 5; i++) step();
        start  = 1'b0;
        resetn = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("rst_mid_hilo", {hi, lo}, {m_hi, m_lo});
        chk("rst_mid_done", 64'(done), 64'd1);
        step();
        resetn = 1'b1;
        step();
        chk("rst_mid_after", 64'(done), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
